// File: rtl/special_controller.sv
// Special-attack sequencer: turns a charged energy bar plus a fire press into
// timed wind-up, active and cooldown windows, and pulses the energy bar empty on commit.
module special_controller #(
    parameter logic [9:0] WINDUP_FRAMES   = 10'd8,
    parameter logic [9:0] ACTIVE_FRAMES   = 10'd20,
    parameter logic [9:0] COOLDOWN_FRAMES = 10'd60
) (
    input  logic       frame_clk,
    input  logic       reset,
    input  logic       energy_ready,
    input  logic       fire_key,
    input  logic       cancel,
    output logic       reset_energy,
    output logic       skill_windup,
    output logic       skill_active,
    output logic       cooldown_busy,
    output logic       charged,
    output logic [3:0] skill_count
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned SKILL_W = 4;

    // A zero-length window still lasts one frame.
    localparam logic [CNT_W-1:0] WINDUP_LAST   = (WINDUP_FRAMES   == 10'd0) ? 10'd0 : WINDUP_FRAMES   - 10'd1;
    localparam logic [CNT_W-1:0] ACTIVE_LAST   = (ACTIVE_FRAMES   == 10'd0) ? 10'd0 : ACTIVE_FRAMES   - 10'd1;
    localparam logic [CNT_W-1:0] COOLDOWN_LAST = (COOLDOWN_FRAMES == 10'd0) ? 10'd0 : COOLDOWN_FRAMES - 10'd1;
    localparam logic [SKILL_W-1:0] SKILL_MAX   = {SKILL_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHARGED,
        S_WINDUP,
        S_ACTIVE,
        S_COOLDOWN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [SKILL_W-1:0]  r_skill_count;
    logic [SKILL_W-1:0]  w_skill_count_nxt;
    logic                r_fire_prev;
    logic                w_fire_rise;
    logic                w_commit;

    logic r_reset_energy;
    logic r_skill_windup;
    logic r_skill_active;
    logic r_cooldown_busy;
    logic r_charged;

    assign w_fire_rise = fire_key & ~r_fire_prev;

    // State, frame counter, key history and registered Moore flags.
    always_ff @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_skill_count   <= '0;
            r_fire_prev     <= 1'b0;
            r_reset_energy  <= 1'b0;
            r_skill_windup  <= 1'b0;
            r_skill_active  <= 1'b0;
            r_cooldown_busy <= 1'b0;
            r_charged       <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_skill_count   <= w_skill_count_nxt;
            r_fire_prev     <= fire_key;
            r_reset_energy  <= w_commit;
            r_skill_windup  <= (w_state_nxt == S_WINDUP);
            r_skill_active  <= (w_state_nxt == S_ACTIVE);
            r_cooldown_busy <= (w_state_nxt == S_COOLDOWN);
            r_charged       <= (w_state_nxt == S_CHARGED);
        end
    end

    // Next-state, counter and commit decode.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_skill_count_nxt = r_skill_count;
        w_commit          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (energy_ready) begin
                    w_state_nxt = S_CHARGED;
                end
            end
            S_CHARGED: begin
                // Losing charge outranks a simultaneous press.
                if (!energy_ready) begin
                    w_state_nxt = S_IDLE;
                end else if (w_fire_rise) begin
                    w_state_nxt = S_WINDUP;
                    w_cnt_nxt   = '0;
                end
            end
            S_WINDUP: begin
                // A hit on the final wind-up frame still aborts the attack.
                if (cancel) begin
                    w_state_nxt = energy_ready ? S_CHARGED : S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == WINDUP_LAST) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = '0;
                    w_commit    = 1'b1;
                    if (r_skill_count != SKILL_MAX) begin
                        w_skill_count_nxt = r_skill_count + SKILL_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_ACTIVE: begin
                if (r_cnt == ACTIVE_LAST) begin
                    w_state_nxt = S_COOLDOWN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_COOLDOWN: begin
                if (r_cnt == COOLDOWN_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign reset_energy  = r_reset_energy;
    assign skill_windup  = r_skill_windup;
    assign skill_active  = r_skill_active;
    assign cooldown_busy = r_cooldown_busy;
    assign charged       = r_charged;
    assign skill_count   = r_skill_count;

endmodule

// File: tb/tb_special_controller.sv
// Directed bench for special_controller at default parameters; expected values hand-derived.
module tb_special_controller;

    logic       frame_clk;
    logic       reset;
    logic       energy_ready;
    logic       fire_key;
    logic       cancel;
    logic       reset_energy;
    logic       skill_windup;
    logic       skill_active;
    logic       cooldown_busy;
    logic       charged;
    logic [3:0] skill_count;

    int n_checks;
    int n_fail;

    special_controller dut (
        .frame_clk     (frame_clk),
        .reset         (reset),
        .energy_ready  (energy_ready),
        .fire_key      (fire_key),
        .cancel        (cancel),
        .reset_energy  (reset_energy),
        .skill_windup  (skill_windup),
        .skill_active  (skill_active),
        .cooldown_busy (cooldown_busy),
        .charged       (charged),
        .skill_count   (skill_count)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Flag vector {charged, windup, active, cooldown, reset_energy}.
    function automatic logic [4:0] flags();
        return {charged, skill_windup, skill_active, cooldown_busy, reset_energy};
    endfunction

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        energy_ready = 1'b0;
        fire_key     = 1'b0;
        cancel       = 1'b0;
        ticks(2);
        check("reset_flags", 32'(flags()), 32'd0);
        check("reset_count", 32'(skill_count), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_flags", 32'(flags()), 32'd0);

        // Single attack: 8 windup, 20 active, 60 cooldown frames.
        energy_ready = 1'b1;
        tick();
        check("charged_after_ready", 32'(flags()), 32'b10000);
        fire_key = 1'b1;
        tick();
        fire_key = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("windup_phase", 32'(flags()), 32'b01000);
            tick();
        end
        check("commit_count", 32'(skill_count), 32'd1);
        for (int i = 0; i < 20; i++) begin
            check("active_phase", 32'(flags()), (i == 0) ? 32'b00101 : 32'b00100);
            tick();
        end
        for (int i = 0; i < 60; i++) begin
            check("cooldown_phase", 32'(flags()), 32'b00010);
            tick();
        end
        check("idle_gap", 32'(flags()), 32'd0);
        tick();
        check("recharged", 32'(flags()), 32'b10000);

        // Held key: one windup only, then needs a release.
        fire_key = 1'b1;
        tick();
        check("held_windup", 32'(flags()), 32'b01000);
        ticks(88);
        check("held_idle", 32'(flags()), 32'd0);
        check("held_count", 32'(skill_count), 32'd2);
        ticks(5);
        check("held_no_refire", 32'(flags()), 32'b10000);
        fire_key = 1'b0;
        tick();
        check("released_charged", 32'(flags()), 32'b10000);
        fire_key = 1'b1;
        tick();
        check("repress_windup", 32'(flags()), 32'b01000);

        // Cancel on windup frame 5.
        ticks(4);
        check("windup_f5", 32'(flags()), 32'b01000);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_f5", 32'(flags()), 32'b10000);
        check("cancel_f5_count", 32'(skill_count), 32'd2);
        ticks(3);
        check("cancel_no_pulse", 32'(flags()), 32'b10000);

        // Cancel on the final windup frame beats commit.
        fire_key = 1'b0;
        tick();
        fire_key = 1'b1;
        tick();
        ticks(7);
        check("windup_last", 32'(flags()), 32'b01000);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_last", 32'(flags()), 32'b10000);
        check("cancel_last_count", 32'(skill_count), 32'd2);

        // Energy drop together with a rise goes to IDLE.
        fire_key = 1'b0;
        tick();
        fire_key     = 1'b1;
        energy_ready = 1'b0;
        tick();
        check("drop_with_rise", 32'(flags()), 32'd0);
        energy_ready = 1'b1;
        tick();
        check("held_after_drop", 32'(flags()), 32'b10000);
        tick();
        check("held_after_drop2", 32'(flags()), 32'b10000);

        // Async reset in the first active frame.
        fire_key = 1'b0;
        tick();
        fire_key = 1'b1;
        tick();
        fire_key = 1'b0;
        ticks(8);
        check("pre_reset_active", 32'(flags()), 32'b00101);
        check("pre_reset_count", 32'(skill_count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("async_flags", 32'(flags()), 32'd0);
        check("async_count", 32'(skill_count), 32'd0);
        energy_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_idle", 32'(flags()), 32'd0);
        energy_ready = 1'b1;
        tick();
        check("post_reset_charged", 32'(flags()), 32'b10000);

        // 17 attacks saturate the counter; a press in cooldown is ignored.
        for (int k = 0; k < 17; k++) begin
            fire_key = 1'b1;
            tick();
            fire_key = 1'b0;
            check("sat_windup", 32'(flags()), 32'b01000);
            ticks(8);
            check("sat_count", 32'(skill_count), (k < 15) ? 32'(k + 1) : 32'd15);
            ticks(20);
            check("sat_cooldown", 32'(flags()), 32'b00010);
            if (k == 0) begin
                fire_key = 1'b1;
                tick();
                fire_key = 1'b0;
                check("cooldown_press", 32'(flags()), 32'b00010);
                ticks(59);
            end else begin
                ticks(60);
            end
            check("sat_idle", 32'(flags()), 32'd0);
            tick();
            check("sat_recharged", 32'(flags()), 32'b10000);
        end
        check("sat_final", 32'(skill_count), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
